// File: rtl/async_fifo_rd_drain.sv
// async_fifo_rd_drain: read-domain consumer for the async FIFO.
// Pops the FIFO, hides its 1-cycle read latency in a 2-entry buffer,
// and presents words as a valid/ready stream with burst framing.
// Ports:
//   rclk, rrst            clock, sync active-high reset
//   enable, flush         allow pops / discard FIFO contents
//   fifo_empty, fifo_data, fifo_read_error, fifo_r_en   FIFO read port
//   m_valid, m_data, m_last, m_ready                     output stream
//   flush_done, rd_err, word_count                       status
module async_fifo_rd_drain #(
    parameter int DATA_WIDTH = 8,
    parameter int BURST_LEN  = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  rclk,
    input  logic                  rrst,
    input  logic                  enable,
    input  logic                  flush,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    input  logic                  fifo_read_error,
    output logic                  fifo_r_en,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    input  logic                  m_ready,
    output logic                  flush_done,
    output logic                  rd_err,
    output logic [CNT_WIDTH-1:0]  word_count
);

    localparam int IW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(BURST_LEN - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FLUSH
    } state_t;

    state_t                  state;
    state_t                  state_nx;
    logic [1:0]              buf_cnt;
    logic                    inflight;
    logic [DATA_WIDTH-1:0]   data0;
    logic [DATA_WIDTH-1:0]   data1;
    logic                    last0;
    logic                    last1;
    logic [IW-1:0]           burst_idx;
    logic                    push;
    logic                    pop;
    logic                    flush_enter;
    logic                    cap_last;
    logic                    wr_slot1;
    logic [2:0]              occupancy;

    assign m_valid     = (buf_cnt != 2'd0);
    assign m_data      = data0;
    assign m_last      = last0;
    assign pop         = m_valid && m_ready;
    assign flush_enter = (state != FLUSH) && flush;
    // Words arriving in FLUSH, or on the cycle FLUSH is entered, are dropped.
    assign push        = inflight && !fifo_read_error &&
                         (state != FLUSH) && !flush_enter;
    assign cap_last    = (burst_idx == LAST_IDX);
    // Tail slot after this cycle's pop has shifted the head.
    assign wr_slot1    = (buf_cnt == 2'd2) || ((buf_cnt == 2'd1) && !pop);
    assign occupancy   = {1'b0, buf_cnt} + {2'b00, inflight};

    always_comb begin
        state_nx   = state;
        fifo_r_en  = 1'b0;
        flush_done = 1'b0;
        unique case (state)
            IDLE: begin
                if (flush)
                    state_nx = FLUSH;
                else if (enable)
                    state_nx = RUN;
            end
            RUN: begin
                // A same-cycle pop frees a slot, so 1 word/cycle is sustained.
                fifo_r_en = !fifo_empty && ((occupancy < 3'd2) || pop);
                if (flush)
                    state_nx = FLUSH;
                else if (!enable)
                    state_nx = IDLE;
            end
            FLUSH: begin
                fifo_r_en = !fifo_empty;
                if (fifo_empty && !inflight) begin
                    flush_done = 1'b1;
                    state_nx   = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
        if (rrst)
            fifo_r_en = 1'b0;
    end

    always_ff @(posedge rclk) begin
        if (rrst) begin
            state      <= IDLE;
            inflight   <= 1'b0;
            buf_cnt    <= 2'd0;
            data0      <= '0;
            data1      <= '0;
            last0      <= 1'b0;
            last1      <= 1'b0;
            burst_idx  <= '0;
            rd_err     <= 1'b0;
            word_count <= '0;
        end else begin
            state    <= state_nx;
            inflight <= fifo_r_en;
            if (fifo_read_error)
                rd_err <= 1'b1;
            if (pop)
                word_count <= word_count + 1'b1;
            if (flush_enter) begin
                buf_cnt   <= 2'd0;
                burst_idx <= '0;
            end else begin
                if (pop) begin
                    data0 <= data1;
                    last0 <= last1;
                end
                if (push) begin
                    burst_idx <= cap_last ? '0 : burst_idx + 1'b1;
                    if (wr_slot1) begin
                        data1 <= fifo_data;
                        last1 <= cap_last;
                    end else begin
                        data0 <= fifo_data;
                        last0 <= cap_last;
                    end
                end
                if (push && !pop)
                    buf_cnt <= buf_cnt + 2'd1;
                else if (pop && !push)
                    buf_cnt <= buf_cnt - 2'd1;
            end
        end
    end

endmodule

// File: tb/tb_async_fifo_rd_drain.sv
// tb_async_fifo_rd_drain: directed bench for async_fifo_rd_drain.
// Behavioural FIFO model plus a scoreboard of expected stream words.
module tb_async_fifo_rd_drain;

    localparam int BL = 4;

    logic        clk;
    logic        rrst;
    logic        enable;
    logic        flush;
    logic        fifo_empty;
    logic [7:0]  fifo_data;
    logic        fifo_read_error;
    logic        fifo_r_en;
    logic        m_valid;
    logic [7:0]  m_data;
    logic        m_last;
    logic        m_ready;
    logic        flush_done;
    logic        rd_err;
    logic [15:0] word_count;

    int checks = 0;
    int errors = 0;

    logic [7:0] wr_base;
    int         wr_n;
    bit         wr_noexp;
    bit         err_arm;

    logic [7:0] q[$];
    logic [7:0] exp_q[$];
    logic [7:0] fd;
    int         exp_idx;
    int         pops;
    int         accepted;
    int         lasts;
    int         q_size;

    async_fifo_rd_drain #(
        .DATA_WIDTH(8),
        .BURST_LEN(BL),
        .CNT_WIDTH(16)
    ) dut (
        .rclk(clk),
        .rrst(rrst),
        .enable(enable),
        .flush(flush),
        .fifo_empty(fifo_empty),
        .fifo_data(fifo_data),
        .fifo_read_error(fifo_read_error),
        .fifo_r_en(fifo_r_en),
        .m_valid(m_valid),
        .m_data(m_data),
        .m_last(m_last),
        .m_ready(m_ready),
        .flush_done(flush_done),
        .rd_err(rd_err),
        .word_count(word_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // FIFO model on the rising edge, scoreboard on the falling edge.
    initial begin
        fifo_empty      = 1'b1;
        fifo_data       = '0;
        fifo_read_error = 1'b0;
        fd       = '0;
        exp_idx  = 0;
        pops     = 0;
        accepted = 0;
        lasts    = 0;
        q_size   = 0;
        forever begin
            @(posedge clk);
            if (rrst) begin
                q.delete();
            end else begin
                if (fifo_r_en && q.size() > 0) begin
                    fd = q.pop_front();
                    pops++;
                end
                for (int i = 0; i < wr_n; i++) begin
                    q.push_back(wr_base + 8'(i));
                    if (!wr_noexp)
                        exp_q.push_back(wr_base + 8'(i));
                end
            end
            q_size = q.size();
            fifo_data       <= fd;
            fifo_empty      <= (q.size() == 0);
            fifo_read_error <= err_arm && fifo_r_en && !rrst;
            @(negedge clk);
            check("r_en_on_empty", {31'd0, fifo_r_en && fifo_empty}, 0);
            if (m_valid && m_ready) begin
                check("sb_has_word", {31'd0, exp_q.size() != 0}, 1);
                if (exp_q.size() != 0) begin
                    check("data", {24'd0, m_data}, {24'd0, exp_q.pop_front()});
                    check("last", {31'd0, m_last},
                          {31'd0, exp_idx == BL - 1});
                end
                exp_idx = (exp_idx + 1) % BL;
                accepted++;
                if (m_last)
                    lasts++;
            end
            if (rrst || flush) begin
                exp_q.delete();
                exp_idx = 0;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [7:0] base, input int n, input bit noexp);
        wr_base  = base;
        wr_n     = n;
        wr_noexp = noexp;
        tick(1);
        wr_n     = 0;
        wr_noexp = 1'b0;
    endtask

    task automatic do_reset();
        m_ready = 1'b0;
        enable  = 1'b0;
        flush   = 1'b0;
        rrst    = 1'b1;
        tick(2);
        rrst    = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        int a0;
        int l0;
        int done;
        rrst     = 1'b1;
        enable   = 1'b0;
        flush    = 1'b0;
        m_ready  = 1'b0;
        wr_base  = '0;
        wr_n     = 0;
        wr_noexp = 1'b0;
        err_arm  = 1'b0;

        // Reset values
        @(posedge clk);
        @(negedge clk);
        check("rst_r_en", {31'd0, fifo_r_en}, 0);
        check("rst_valid", {31'd0, m_valid}, 0);
        check("rst_data", {24'd0, m_data}, 0);
        check("rst_last", {31'd0, m_last}, 0);
        check("rst_done", {31'd0, flush_done}, 0);
        check("rst_err", {31'd0, rd_err}, 0);
        check("rst_cnt", {16'd0, word_count}, 0);
        tick(1);
        rrst = 1'b0;

        // Basic drain with latency
        enable  = 1'b1;
        m_ready = 1'b1;
        tick(2);
        put(8'h01, 5, 1'b0);
        @(negedge clk);
        check("lat_r_en", {31'd0, fifo_r_en}, 1);
        check("lat_v0", {31'd0, m_valid}, 0);
        @(negedge clk);
        check("lat_v1", {31'd0, m_valid}, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("drain_v", {31'd0, m_valid}, 1);
            check("drain_d", {24'd0, m_data}, i + 1);
        end
        @(negedge clk);
        check("drain_end_v", {31'd0, m_valid}, 0);
        check("drain_cnt", {16'd0, word_count}, 5);
        check("drain_err", {31'd0, rd_err}, 0);

        // Burst framing
        tick(1);
        do_reset();
        enable  = 1'b1;
        m_ready = 1'b1;
        tick(2);
        a0 = accepted;
        l0 = lasts;
        put(8'h30, 9, 1'b0);
        tick(16);
        check("burst_n", accepted - a0, 9);
        check("burst_lasts", lasts - l0, 2);
        check("burst_cnt", {16'd0, word_count}, 9);

        // Backpressure
        do_reset();
        enable = 1'b1;
        tick(2);
        p0 = pops;
        put(8'h10, 10, 1'b0);
        tick(8);
        check("bp_pops", pops - p0, 2);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_v", {31'd0, m_valid}, 1);
            check("bp_d", {24'd0, m_data}, 8'h10);
        end
        tick(1);
        m_ready = 1'b1;
        tick(20);
        check("bp_cnt", {16'd0, word_count}, 10);
        check("bp_pops_all", pops - p0, 10);
        check("bp_sb_empty", exp_q.size(), 0);

        // Flush
        do_reset();
        enable = 1'b1;
        tick(2);
        put(8'h20, 20, 1'b0);
        tick(6);
        m_ready = 1'b1;
        tick(3);
        m_ready = 1'b0;
        flush   = 1'b1;
        tick(1);
        flush   = 1'b0;
        @(negedge clk);
        check("fl_valid", {31'd0, m_valid}, 0);
        check("fl_cnt3", {16'd0, word_count}, 3);
        done = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (flush_done)
                done++;
            check("fl_valid_low", {31'd0, m_valid}, 0);
        end
        check("fl_done_pulses", done, 1);
        check("fl_q_empty", q_size, 0);
        check("fl_cnt", {16'd0, word_count}, 3);
        tick(1);
        l0 = lasts;
        m_ready = 1'b1;
        put(8'hAA, 4, 1'b0);
        tick(10);
        check("fl_new_cnt", {16'd0, word_count}, 7);
        check("fl_new_last", lasts - l0, 1);

        // Read error
        do_reset();
        enable  = 1'b1;
        m_ready = 1'b1;
        err_arm = 1'b1;
        tick(2);
        put(8'h55, 1, 1'b1);
        tick(3);
        err_arm = 1'b0;
        @(negedge clk);
        check("err_set", {31'd0, rd_err}, 1);
        check("err_nobuf", {31'd0, m_valid}, 0);
        tick(1);
        put(8'h66, 1, 1'b0);
        tick(6);
        check("err_cnt", {16'd0, word_count}, 1);
        check("err_sticky", {31'd0, rd_err}, 1);

        // Reset mid-stream
        put(8'h40, 10, 1'b0);
        tick(4);
        rrst = 1'b1;
        @(negedge clk);
        check("mid_r_en", {31'd0, fifo_r_en}, 0);
        tick(1);
        @(negedge clk);
        check("mid_valid", {31'd0, m_valid}, 0);
        check("mid_data", {24'd0, m_data}, 0);
        check("mid_last", {31'd0, m_last}, 0);
        check("mid_done", {31'd0, flush_done}, 0);
        check("mid_err", {31'd0, rd_err}, 0);
        check("mid_cnt", {16'd0, word_count}, 0);
        tick(1);
        rrst = 1'b0;
        tick(2);
        put(8'h50, 2, 1'b0);
        tick(8);
        check("post_cnt", {16'd0, word_count}, 2);
        check("post_sb_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
